// File: rtl/ms_time_counter.sv
// ms_time_counter: turns the millisecond square wave into ticks and keeps a
// time-of-day (ms, s, min, h). A valid/ready port loads a new time, and a
// watchdog flags the loss of the incoming timebase.
`timescale 1ns/1ps

module ms_time_counter #(
  parameter int MS_PER_SEC     = 1000,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       Clk_50MHz,
  input  logic       Reset,
  input  logic       ms_in,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_error,
  output logic [9:0] ms_cnt,
  output logic [5:0] sec_cnt,
  output logic [5:0] min_cnt,
  output logic [4:0] hour_cnt,
  output logic       sec_pulse,
  output logic       day_pulse,
  output logic       tick_lost
);

  localparam logic [9:0]  MS_LAST  = 10'(MS_PER_SEC - 1);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    RUN,
    CHECK
  } state_t;

  state_t      state;
  logic        ms_d;
  logic        tick;
  logic [15:0] to_cnt;
  logic [4:0]  hold_hour;
  logic [5:0]  hold_min;
  logic [5:0]  hold_sec;
  logic        load_ok;

  logic [9:0]  ms_next;
  logic [5:0]  sec_next;
  logic [5:0]  min_next;
  logic [4:0]  hour_next;
  logic        sec_wrap;
  logic        day_wrap;

  assign tick    = ms_in & ~ms_d;
  assign load_ok = (hold_hour <= 5'd23) && (hold_min <= 6'd59) && (hold_sec <= 6'd59);

  // Edge-detect history and timebase watchdog: saturates at the limit, cleared by any tick
  always_ff @(posedge Clk_50MHz) begin
    if (Reset) begin
      ms_d      <= 1'b0;
      to_cnt    <= '0;
      tick_lost <= 1'b0;
    end else begin
      ms_d <= ms_in;
      if (tick) begin
        to_cnt    <= '0;
        tick_lost <= 1'b0;
      end else if (to_cnt != TO_LIMIT) begin
        to_cnt <= to_cnt + 16'd1;
        if (to_cnt == TO_LAST) begin
          tick_lost <= 1'b1;
        end
      end
    end
  end

  // Full carry chain for one tick, resolved in a single cycle so no out-of-range value is ever stored
  always_comb begin
    ms_next   = ms_cnt + 10'd1;
    sec_next  = sec_cnt;
    min_next  = min_cnt;
    hour_next = hour_cnt;
    sec_wrap  = 1'b0;
    day_wrap  = 1'b0;
    if (ms_cnt == MS_LAST) begin
      ms_next  = '0;
      sec_wrap = 1'b1;
      sec_next = sec_cnt + 6'd1;
      if (sec_cnt == 6'd59) begin
        sec_next = '0;
        min_next = min_cnt + 6'd1;
        if (min_cnt == 6'd59) begin
          min_next  = '0;
          hour_next = hour_cnt + 5'd1;
          if (hour_cnt == 5'd23) begin
            hour_next = '0;
            day_wrap  = 1'b1;
          end
        end
      end
    end
  end

  // Load FSM and time registers; a valid load in CHECK overrides a coincident tick
  always_ff @(posedge Clk_50MHz) begin
    if (Reset) begin
      state     <= RUN;
      set_ready <= 1'b1;
      set_error <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      ms_cnt    <= '0;
      sec_cnt   <= '0;
      min_cnt   <= '0;
      hour_cnt  <= '0;
      hold_hour <= '0;
      hold_min  <= '0;
      hold_sec  <= '0;
    end else begin
      set_error <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;

      if (state == CHECK && load_ok) begin
        ms_cnt   <= '0;
        sec_cnt  <= hold_sec;
        min_cnt  <= hold_min;
        hour_cnt <= hold_hour;
      end else if (tick) begin
        ms_cnt    <= ms_next;
        sec_cnt   <= sec_next;
        min_cnt   <= min_next;
        hour_cnt  <= hour_next;
        sec_pulse <= sec_wrap;
        day_pulse <= day_wrap;
      end

      case (state)
        RUN: begin
          if (set_valid) begin
            hold_hour <= set_hour;
            hold_min  <= set_min;
            hold_sec  <= set_sec;
            state     <= CHECK;
            set_ready <= 1'b0;
          end
        end
        CHECK: begin
          state     <= RUN;
          set_ready <= 1'b1;
          if (!load_ok) begin
            set_error <= 1'b1;
          end
        end
        default: begin
          state     <= RUN;
          set_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_time_counter.sv
// tb_ms_time_counter: self-checking bench for ms_time_counter. A behavioural
// model tracks the time as total milliseconds of the day and queues the
// expected outputs every clock; a monitor pops and compares them. Load
// requests come from a vector table, and the timeout and reset corner cases
// are written out as explicit sequences.
`timescale 1ns/1ps

module tb_ms_time_counter;

  localparam int MS_PER_SEC = 1000;
  localparam int TIMEOUT    = 300;
  localparam int DAY_MS     = 24 * 3600 * MS_PER_SEC;

  logic       clk = 1'b0;
  logic       reset;
  logic       ms_in;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_error;
  logic [9:0] ms_cnt;
  logic [5:0] sec_cnt;
  logic [5:0] min_cnt;
  logic [4:0] hour_cnt;
  logic       sec_pulse;
  logic       day_pulse;
  logic       tick_lost;

  int checks = 0;
  int errors = 0;
  int sec_seen = 0;
  int day_seen = 0;

  typedef struct packed {
    logic [9:0] ms;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       ready;
    logic       err;
    logic       secp;
    logic       dayp;
    logic       lost;
  } snap_t;

  snap_t exp_q[$];

  typedef struct {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    bit         tick;
    bit         exp_err;
    int         exp_h;
    int         exp_m;
    int         exp_s;
    int         exp_ms;
  } load_vec_t;

  load_vec_t tbl[10];

  // Reference model state
  bit    model_on = 1'b0;
  bit    m_ms_d, m_check, m_tick;
  int    m_hh, m_mm, m_ss, m_time, m_to;
  bit    m_ready, m_err, m_secp, m_dayp, m_lost;
  snap_t m_exp, got, want;

  always #10 clk = ~clk;

  ms_time_counter #(
    .MS_PER_SEC(MS_PER_SEC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clk_50MHz(clk),
    .Reset(reset),
    .ms_in(ms_in),
    .set_valid(set_valid),
    .set_ready(set_ready),
    .set_hour(set_hour),
    .set_min(set_min),
    .set_sec(set_sec),
    .set_error(set_error),
    .ms_cnt(ms_cnt),
    .sec_cnt(sec_cnt),
    .min_cnt(min_cnt),
    .hour_cnt(hour_cnt),
    .sec_pulse(sec_pulse),
    .day_pulse(day_pulse),
    .tick_lost(tick_lost)
  );

  function void modelTick();
    m_time = m_time + 1;
    if (m_time % MS_PER_SEC == 0) m_secp = 1'b1;
    if (m_time == DAY_MS) begin
      m_time = 0;
      m_dayp = 1'b1;
    end
  endfunction

  // Model: advance one clock from the inputs seen at this edge, queue the expected outputs
  always @(posedge clk) begin
    if (reset === 1'b1) begin
      model_on = 1'b1;
      m_ms_d = 0; m_check = 0; m_time = 0; m_to = 0;
      m_ready = 1; m_err = 0; m_secp = 0; m_dayp = 0; m_lost = 0;
    end else if (model_on) begin
      m_tick = ms_in && !m_ms_d;
      m_ms_d = ms_in;
      m_err = 0; m_secp = 0; m_dayp = 0;
      if (m_check) begin
        m_check = 0;
        m_ready = 1;
        if (m_hh <= 23 && m_mm <= 59 && m_ss <= 59) begin
          m_time = ((m_hh * 60 + m_mm) * 60 + m_ss) * MS_PER_SEC;
        end else begin
          m_err = 1;
          if (m_tick) modelTick();
        end
      end else begin
        if (m_tick) modelTick();
        if (set_valid) begin
          m_hh = int'(set_hour);
          m_mm = int'(set_min);
          m_ss = int'(set_sec);
          m_check = 1;
          m_ready = 0;
        end
      end
      if (m_tick) begin
        m_to = 0;
        m_lost = 0;
      end else if (m_to < TIMEOUT) begin
        m_to = m_to + 1;
        if (m_to == TIMEOUT) m_lost = 1;
      end
    end
    if (model_on) begin
      m_exp.ms    = 10'(m_time % MS_PER_SEC);
      m_exp.sec   = 6'((m_time / MS_PER_SEC) % 60);
      m_exp.min   = 6'((m_time / (60 * MS_PER_SEC)) % 60);
      m_exp.hour  = 5'(m_time / (3600 * MS_PER_SEC));
      m_exp.ready = m_ready;
      m_exp.err   = m_err;
      m_exp.secp  = m_secp;
      m_exp.dayp  = m_dayp;
      m_exp.lost  = m_lost;
      exp_q.push_back(m_exp);
    end
  end

  // Monitor: compare every settled DUT output set against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {ms_cnt, sec_cnt, min_cnt, hour_cnt, set_ready, set_error, sec_pulse, day_pulse, tick_lost};
      checks = checks + 1;
      if (got !== want) begin
        errors = errors + 1;
        $display("[TB] FAIL cycle_state t=%0t got %0d:%0d:%0d.%0d rdy=%b err=%b sp=%b dp=%b lost=%b want %0d:%0d:%0d.%0d rdy=%b err=%b sp=%b dp=%b lost=%b",
                 $time, got.hour, got.min, got.sec, got.ms, got.ready, got.err, got.secp, got.dayp, got.lost,
                 want.hour, want.min, want.sec, want.ms, want.ready, want.err, want.secp, want.dayp, want.lost);
      end
      if (sec_pulse === 1'b1) sec_seen = sec_seen + 1;
      if (day_pulse === 1'b1) day_seen = day_seen + 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %0d want %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) ms_in = 1'b1;
      @(negedge clk) ms_in = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s, input bit tick_in_check);
    int waited;
    waited = 0;
    @(negedge clk);
    while (set_ready !== 1'b1 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_load", int'(set_ready), 1);
    set_valid = 1'b1;
    set_hour  = h;
    set_min   = m;
    set_sec   = s;
    @(negedge clk);
    set_valid = 1'b0;
    checkOutput("ready_low_in_check", int'(set_ready), 0);
    if (tick_in_check) ms_in = 1'b1;
    @(negedge clk);
    checkOutput("ready_back_high", int'(set_ready), 1);
    if (tick_in_check) ms_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prev_ms;

    tbl[0] = '{5'd12, 6'd34, 6'd56, 1'b0, 1'b0, 12, 34, 56, 0};
    tbl[1] = '{5'd24, 6'd0,  6'd0,  1'b0, 1'b1, 12, 34, 56, 0};
    tbl[2] = '{5'd10, 6'd60, 6'd0,  1'b0, 1'b1, 12, 34, 56, 0};
    tbl[3] = '{5'd0,  6'd0,  6'd0,  1'b0, 1'b0, 0,  0,  0,  0};
    tbl[4] = '{5'd0,  6'd0,  6'd60, 1'b0, 1'b1, 0,  0,  0,  0};
    tbl[5] = '{5'd12, 6'd34, 6'd56, 1'b1, 1'b0, 12, 34, 56, 0};
    tbl[6] = '{5'd10, 6'd60, 6'd0,  1'b1, 1'b1, 12, 34, 56, 1};
    tbl[7] = '{5'd24, 6'd0,  6'd0,  1'b1, 1'b1, 12, 34, 56, 2};
    tbl[8] = '{5'd23, 6'd59, 6'd59, 1'b0, 1'b0, 23, 59, 59, 0};
    tbl[9] = '{5'd31, 6'd63, 6'd63, 1'b0, 1'b1, 23, 59, 59, 0};

    reset = 1'b1; ms_in = 1'b0; set_valid = 1'b0;
    set_hour = '0; set_min = '0; set_sec = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ms", int'(ms_cnt), 0);
    checkOutput("reset_hour", int'(hour_cnt), 0);
    checkOutput("reset_ready", int'(set_ready), 1);
    checkOutput("reset_lost", int'(tick_lost), 0);
    reset = 1'b0;

    // One full second of ticks from reset
    #1;
    sec_seen = 0;
    day_seen = 0;
    applyTicks(MS_PER_SEC);
    @(posedge clk); #1;
    checkOutput("sec1_ms", int'(ms_cnt), 0);
    checkOutput("sec1_sec", int'(sec_cnt), 1);
    checkOutput("sec1_min", int'(min_cnt), 0);
    checkOutput("sec1_hour", int'(hour_cnt), 0);
    checkOutput("sec1_sec_pulses", sec_seen, 1);
    checkOutput("sec1_day_pulses", day_seen, 0);
    checkOutput("sec1_lost", int'(tick_lost), 0);

    // Load request vectors
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].hour, tbl[i].min, tbl[i].sec, tbl[i].tick);
      checkOutput($sformatf("load%0d_error", i), int'(set_error), int'(tbl[i].exp_err));
      checkOutput($sformatf("load%0d_hour", i), int'(hour_cnt), tbl[i].exp_h);
      checkOutput($sformatf("load%0d_min", i), int'(min_cnt), tbl[i].exp_m);
      checkOutput($sformatf("load%0d_sec", i), int'(sec_cnt), tbl[i].exp_s);
      checkOutput($sformatf("load%0d_ms", i), int'(ms_cnt), tbl[i].exp_ms);
      @(negedge clk);
      checkOutput($sformatf("load%0d_error_gone", i), int'(set_error), 0);
    end

    // 23:59:59.000 plus one second wraps the day
    #1;
    sec_seen = 0;
    day_seen = 0;
    applyTicks(MS_PER_SEC);
    @(posedge clk); #1;
    checkOutput("day_ms", int'(ms_cnt), 0);
    checkOutput("day_sec", int'(sec_cnt), 0);
    checkOutput("day_min", int'(min_cnt), 0);
    checkOutput("day_hour", int'(hour_cnt), 0);
    checkOutput("day_sec_pulses", sec_seen, 1);
    checkOutput("day_day_pulses", day_seen, 1);

    // Random traffic, checked cycle by cycle by the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ms_in     = 1'($urandom_range(0, 1));
      set_valid = ($urandom_range(0, 3) == 0);
      set_hour  = 5'($urandom_range(0, 31));
      set_min   = 6'($urandom_range(0, 63));
      set_sec   = 6'($urandom_range(0, 63));
      reset     = ($urandom_range(0, 199) == 0);
    end
    @(negedge clk);
    reset = 1'b0; set_valid = 1'b0; ms_in = 1'b0;
    repeat (3) @(negedge clk);

    // Timebase loss and recovery
    applyTicks(1);
    repeat (TIMEOUT - 1) @(negedge clk);
    checkOutput("lost_before_limit", int'(tick_lost), 0);
    @(negedge clk);
    checkOutput("lost_at_limit", int'(tick_lost), 1);
    repeat (20) @(negedge clk);
    checkOutput("lost_held", int'(tick_lost), 1);
    prev_ms = int'(ms_cnt);
    ms_in = 1'b1;
    @(negedge clk);
    ms_in = 1'b0;
    checkOutput("lost_cleared", int'(tick_lost), 0);
    checkOutput("lost_ms_step", int'(ms_cnt), (prev_ms + 1) % MS_PER_SEC);

    // Reset landing in the CHECK cycle of a valid load
    @(negedge clk);
    set_valid = 1'b1;
    set_hour = 5'd5; set_min = 6'd6; set_sec = 6'd7;
    @(negedge clk);
    set_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rstchk_ms", int'(ms_cnt), 0);
    checkOutput("rstchk_sec", int'(sec_cnt), 0);
    checkOutput("rstchk_ready", int'(set_ready), 1);
    @(negedge clk);
    checkOutput("rstchk_hour_after", int'(hour_cnt), 0);
    checkOutput("rstchk_min_after", int'(min_cnt), 0);
    checkOutput("rstchk_error_after", int'(set_error), 0);
    checkOutput("rstchk_ready_after", int'(set_ready), 1);

    repeat (2) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
